// File: rtl/udma_i2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_i2s_pkg : shared types for the I2S/PDM RX scheduler              |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package udma_i2s_pkg;

    typedef enum logic [1:0] {
        CH0_ONLY   = 2'b00,
        CH1_ONLY   = 2'b01,
        INTERLEAVE = 2'b10,
        RR         = 2'b11
    } chan_mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        WAIT_CH0 = 2'b10,
        WAIT_CH1 = 2'b11
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/udma_i2s_rx_hold.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_i2s_rx_hold : one-entry sample hold with drain and overrun pulse |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module udma_i2s_rx_hold #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  ovf_o
);

    logic                  full_q;
    logic                  full_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    // A drain in the same cycle frees the slot, so the new sample reloads it.
    assign ovf_o = load_i & full_q & ~drain_i;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (load_i && !ovf_o) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/udma_i2s_rx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_i2s_rx_sched : merges I2S ch0/ch1 samples into one RX stream     |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module udma_i2s_rx_sched
    import udma_i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic                  cfg_err_clr_i,
    input  logic [DATA_WIDTH-1:0] ch0_data_i,
    input  logic                  ch0_valid_i,
    input  logic [DATA_WIDTH-1:0] ch1_data_i,
    input  logic                  ch1_valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  chan_o,
    output logic [1:0]            err_ovf_o
);

    sched_state_e          state_q;
    chan_mode_e            mode_q;
    logic                  last_grant_q;
    logic                  valid_q;
    logic                  chan_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            err_q;

    logic                  active;
    logic                  out_free;
    logic                  full0, full1;
    logic                  ovf0, ovf1;
    logic                  gnt0, gnt1;
    logic [DATA_WIDTH-1:0] hold0, hold1;

    assign active   = (state_q != IDLE) && cfg_en_i;
    assign out_free = ~valid_q | ready_i;

    udma_i2s_rx_hold #(.DATA_WIDTH(DATA_WIDTH)) u_hold0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (~cfg_en_i),
        .load_i  (ch0_valid_i & active & (mode_q != CH1_ONLY)),
        .drain_i (gnt0),
        .data_i  (ch0_data_i),
        .full_o  (full0),
        .data_o  (hold0),
        .ovf_o   (ovf0)
    );

    udma_i2s_rx_hold #(.DATA_WIDTH(DATA_WIDTH)) u_hold1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (~cfg_en_i),
        .load_i  (ch1_valid_i & active & (mode_q != CH0_ONLY)),
        .drain_i (gnt1),
        .data_i  (ch1_data_i),
        .full_o  (full1),
        .data_o  (hold1),
        .ovf_o   (ovf1)
    );

    // A grant is only issued when the output register can take the word,
    // so a grant is also the drain strobe of the matching hold.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (active && out_free) begin
            case (state_q)
                RUN: begin
                    if (full0 && full1) begin
                        gnt0 = last_grant_q;
                        gnt1 = ~last_grant_q;
                    end else begin
                        gnt0 = full0;
                        gnt1 = full1;
                    end
                end
                WAIT_CH0: gnt0 = full0;
                WAIT_CH1: gnt1 = full1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mode_q       <= CH0_ONLY;
            last_grant_q <= 1'b1;
            valid_q      <= 1'b0;
            chan_q       <= 1'b0;
            data_q       <= '0;
            err_q        <= 2'b00;
        end else begin
            if (!cfg_en_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        mode_q  <= chan_mode_e'(cfg_mode_i);
                        state_q <= (chan_mode_e'(cfg_mode_i) == INTERLEAVE) ? WAIT_CH0 : RUN;
                    end
                    WAIT_CH0: if (gnt0) state_q <= WAIT_CH1;
                    WAIT_CH1: if (gnt1) state_q <= WAIT_CH0;
                    default: ;
                endcase
            end

            if (state_q == RUN && (gnt0 || gnt1)) begin
                last_grant_q <= gnt1;
            end

            if (out_free) begin
                valid_q <= gnt0 | gnt1;
                if (gnt0 || gnt1) begin
                    data_q <= gnt1 ? hold1 : hold0;
                    chan_q <= gnt1;
                end
            end

            // A fresh overrun outranks a clear landing in the same cycle.
            err_q <= (err_q & ~{2{cfg_err_clr_i}}) | {ovf1, ovf0};
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign chan_o    = chan_q;
    assign err_ovf_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_udma_i2s_rx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_udma_i2s_rx_sched : self-checking bench for the I2S RX scheduler   |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_udma_i2s_rx_sched;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, en, clr, v0, v1, rdy;
    logic [1:0]    mode;
    logic [DW-1:0] d0, d1;
    logic [DW-1:0] data_o;
    logic          valid_o, chan_o;
    logic [1:0]    err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    udma_i2s_rx_sched #(.DATA_WIDTH(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_en_i      (en),
        .cfg_mode_i    (mode),
        .cfg_err_clr_i (clr),
        .ch0_data_i    (d0),
        .ch0_valid_i   (v0),
        .ch1_data_i    (d1),
        .ch1_valid_i   (v1),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (rdy),
        .chan_o        (chan_o),
        .err_ovf_o     (err_o)
    );

    // Reference: pending sample per channel, expected next channel for
    // interleave, preferred channel for a tie, and the output word.
    bit            m_on;
    bit [1:0]      m_mode;
    bit            m_turn, m_prefer;
    bit            m_pend [2];
    logic [DW-1:0] m_pv   [2];
    bit            m_ov, m_oc;
    logic [DW-1:0] m_od;
    bit [1:0]      m_err;

    function automatic bit accepts(int c);
        return m_mode[1] || (m_mode[0] == c[0]);
    endfunction

    always @(posedge clk) begin
        int            pick;
        bit            take, freed;
        bit [1:0]      nerr;
        bit            vin [2];
        logic [DW-1:0] din [2];
        vin[0] = v0; vin[1] = v1; din[0] = d0; din[1] = d1;
        if (rst) begin
            m_on = 0; m_pend[0] = 0; m_pend[1] = 0; m_ov = 0; m_oc = 0;
            m_od = '0; m_err = 0; m_prefer = 0; m_turn = 0; m_mode = 0;
        end else begin
            take = !m_ov || rdy;
            pick = -1;
            if (m_on && en && take) begin
                if (m_mode == 2'b10) begin
                    if (m_pend[m_turn]) pick = m_turn;
                end else if (m_pend[0] && m_pend[1]) pick = m_prefer;
                else if (m_pend[0]) pick = 0;
                else if (m_pend[1]) pick = 1;
            end
            if (take) begin
                m_ov = (pick >= 0);
                if (pick >= 0) begin
                    m_od = m_pv[pick];
                    m_oc = pick[0];
                end
            end
            nerr = clr ? 2'b00 : m_err;
            if (!en) begin
                m_on = 0; m_pend[0] = 0; m_pend[1] = 0;
            end else if (!m_on) begin
                m_on = 1; m_mode = mode; m_turn = 0;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    freed = (pick == c);
                    if (vin[c] && accepts(c)) begin
                        if (m_pend[c] && !freed) nerr[c] = 1'b1;
                        else begin
                            m_pend[c] = 1; m_pv[c] = din[c];
                        end
                    end else if (freed) m_pend[c] = 0;
                end
                if (pick >= 0) begin
                    if (m_mode == 2'b10) m_turn = ~pick[0];
                    else m_prefer = ~pick[0];
                end
            end
            m_err = nerr;
        end
    end

    task automatic step(input bit a0, input logic [DW-1:0] x0, input bit a1,
                        input logic [DW-1:0] x1, input bit r);
        v0 = a0; d0 = x0; v1 = a1; d1 = x1; rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; clr = 0; mode = 0;
        step(0, 0, 0, 0, 1);
        step(1, 'h11, 1, 'h22, 1);
        n_cmp++;
        if (valid_o !== 1'b0 || chan_o !== 1'b0 || data_o !== '0 || err_o !== 2'b00) begin
            n_bad++;
            $display("FAIL reset: got v=%b c=%b d=%h e=%b, want all zero", valid_o, chan_o, data_o, err_o);
        end
        rst = 0;
    endtask

    task automatic test_mode00();
        en = 0; mode = 2'b00; clr = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) en = 1;
            case (i)
                2: step(1, 'hA0, 1, 'h55, 1);
                4: step(1, 'hA1, 1, 'h56, 1);
                default: step(0, 0, 0, 0, 1);
            endcase
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL m00[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
            if (i == 2 || i == 3 || i == 5 || i == 9) begin
                n_cmp++;
                if ((i == 2 && valid_o !== 1'b0) ||
                    (i == 3 && {valid_o, chan_o, data_o} !== {1'b1, 1'b0, 32'hA0}) ||
                    (i == 5 && {valid_o, chan_o, data_o} !== {1'b1, 1'b0, 32'hA1}) ||
                    (i == 9 && err_o !== 2'b00)) begin
                    n_bad++;
                    $display("FAIL m00_dir[%0d]: got v=%b c=%b d=%h e=%b", i, valid_o, chan_o, data_o, err_o);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 3) != 0);
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL m00_rnd[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
        end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 9; i++) begin
            en = (i != 0); clr = (i == 0); mode = 2'b10;
            case (i)
                2: step(0, 0, 1, 'hB0, 1);
                3: step(0, 0, 1, 'hB1, 1);
                4: step(1, 'hC0, 0, 0, 1);
                default: step(0, 0, 0, 0, 1);
            endcase
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL ilv[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
            if (i == 3 || i == 5 || i == 6 || i == 8) begin
                n_cmp++;
                if ((i == 3 && err_o !== 2'b10) ||
                    (i == 5 && {valid_o, chan_o, data_o} !== {1'b1, 1'b0, 32'hC0}) ||
                    (i == 6 && {valid_o, chan_o, data_o} !== {1'b1, 1'b1, 32'hB0}) ||
                    (i == 8 && err_o !== 2'b10)) begin
                    n_bad++;
                    $display("FAIL ilv_dir[%0d]: got v=%b c=%b d=%h e=%b", i, valid_o, chan_o, data_o, err_o);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 3) != 0);
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL ilv_rnd[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
        end
    endtask

    task automatic test_rr();
        for (int i = 0; i < 11; i++) begin
            rst = (i == 0); en = (i != 0); mode = 2'b11; clr = 0;
            case (i)
                2: step(1, 'h10, 1, 'h20, 1);
                5: step(1, 'h12, 0, 0, 1);
                7: step(1, 'h11, 1, 'h21, 1);
                default: step(0, 0, 0, 0, 1);
            endcase
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL rr[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
            if (i == 3 || i == 4 || i == 8 || i == 9) begin
                n_cmp++;
                if ((i == 3 && {valid_o, chan_o, data_o} !== {1'b1, 1'b0, 32'h10}) ||
                    (i == 4 && {valid_o, chan_o, data_o} !== {1'b1, 1'b1, 32'h20}) ||
                    (i == 8 && {valid_o, chan_o, data_o} !== {1'b1, 1'b1, 32'h21}) ||
                    (i == 9 && {valid_o, chan_o, data_o} !== {1'b1, 1'b0, 32'h11})) begin
                    n_bad++;
                    $display("FAIL rr_dir[%0d]: got v=%b c=%b d=%h", i, valid_o, chan_o, data_o);
                end
            end
        end
        rst = 0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            en = (i != 0); mode = 2'b00; clr = (i == 0 || i == 7 || i == 9);
            case (i)
                2: step(1, 'h30, 0, 0, 1);
                3: step(1, 'h31, 0, 0, 0);
                4: step(0, 0, 0, 0, 0);
                5: step(1, 'h32, 0, 0, 0);
                6: step(0, 0, 0, 0, 0);
                7: step(1, 'h33, 0, 0, 0);
                default: step(0, 0, 0, 0, 1);
            endcase
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL bp[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
            if (i == 3 || i == 5 || i == 7 || i == 8 || i == 9) begin
                n_cmp++;
                if ((i == 3 && {valid_o, data_o} !== {1'b1, 32'h30}) ||
                    (i == 5 && {valid_o, data_o, err_o} !== {1'b1, 32'h30, 2'b01}) ||
                    (i == 7 && {valid_o, data_o, err_o} !== {1'b1, 32'h30, 2'b01}) ||
                    (i == 8 && {valid_o, data_o} !== {1'b1, 32'h31}) ||
                    (i == 9 && {valid_o, err_o} !== {1'b0, 2'b00})) begin
                    n_bad++;
                    $display("FAIL bp_dir[%0d]: got v=%b d=%h e=%b", i, valid_o, data_o, err_o);
                end
            end
        end
        clr = 0;
    endtask

    task automatic test_disable();
        for (int i = 0; i < 16; i++) begin
            en = !(i == 0 || i == 4 || i == 5 || i == 6 || i == 12);
            mode = (i >= 8) ? 2'b11 : 2'b00;
            clr = 0;
            case (i)
                2:  step(1, 'h40, 0, 0, 0);
                3:  step(1, 'h41, 0, 0, 0);
                4:  step(0, 0, 0, 0, 0);
                5:  step(0, 0, 0, 0, 0);
                8:  step(0, 0, 1, 'h50, 1);
                10: step(1, 'h42, 0, 0, 1);
                14: step(0, 0, 1, 'h51, 1);
                default: step(0, 0, 0, 0, 1);
            endcase
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL dis[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
            if (i == 5 || i == 6 || i == 9 || i == 11 || i == 15) begin
                n_cmp++;
                if ((i == 5 && {valid_o, data_o} !== {1'b1, 32'h40}) ||
                    (i == 6 && valid_o !== 1'b0) ||
                    (i == 9 && {valid_o, err_o} !== {1'b0, 2'b00}) ||
                    (i == 11 && {valid_o, chan_o, data_o} !== {1'b1, 1'b0, 32'h42}) ||
                    (i == 15 && {valid_o, chan_o, data_o} !== {1'b1, 1'b1, 32'h51})) begin
                    n_bad++;
                    $display("FAIL dis_dir[%0d]: got v=%b c=%b d=%h e=%b", i, valid_o, chan_o, data_o, err_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            rst = (i == 2); en = 1; mode = 2'b11; clr = 0;
            case (i)
                0: step(1, 'h60, 1, 'h70, 0);
                1: step(0, 0, 0, 0, 0);
                4: step(1, 'h61, 1, 'h71, 1);
                default: step(0, 0, 0, 0, 1);
            endcase
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL rmid[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
            if (i == 2 || i == 5) begin
                n_cmp++;
                if ((i == 2 && {valid_o, chan_o, data_o, err_o} !== {1'b0, 1'b0, 32'h0, 2'b00}) ||
                    (i == 5 && {valid_o, chan_o, data_o} !== {1'b1, 1'b0, 32'h61})) begin
                    n_bad++;
                    $display("FAIL rmid_dir[%0d]: got v=%b c=%b d=%h e=%b", i, valid_o, chan_o, data_o, err_o);
                end
            end
        end
        rst = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 29) == 0) en = ~en;
            mode = 2'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 19) == 0);
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 9) < 7);
            n_cmp++;
            if (valid_o !== m_ov || err_o !== m_err || (m_ov && (chan_o !== m_oc || data_o !== m_od))) begin
                n_bad++;
                $display("FAIL rnd[%0d]: got v=%b c=%b d=%h e=%b, want v=%b c=%b d=%h e=%b",
                         i, valid_o, chan_o, data_o, err_o, m_ov, m_oc, m_od, m_err);
            end
        end
        rst = 0; clr = 0;
    endtask

    initial begin
        rst = 1; en = 0; clr = 0; mode = 0; v0 = 0; v1 = 0; d0 = 0; d1 = 0; rdy = 1;
        test_reset();
        test_mode00();
        test_interleave();
        test_rr();
        test_backpressure();
        test_disable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
